cpu_stack_file: RTL and testbench
=================================

Name: cpu_stack_file

Overview:
- Operand-stack storage for the stack CPU; consumes the stage-5 writeback requests: pop count, push strobe and 35-bit push entry.
- Each cycle it applies "pop N, then optionally push one entry" atomically.
- Presents registered top-of-stack (TOS) and next-on-stack (NOS) entries, occupancy and error status to the front of the pipeline.

Parameters:
- DEPTH, 64, number of 35-bit entries held; power of two, at least 4.
- AW, 6, log2(DEPTH); the occupancy counter is AW+1 bits wide.
- WIDTH, 35, entry width; must match the writeback push bus.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_b  input  1  synchronous active-low reset.
- st__push_5a  input  1  push request; push st__to_push_5a after the pop is applied.
- st__to_pop_5a  input  11  unsigned number of entries to pop this cycle; 0 means none.
- st__to_push_5a  input  WIDTH  entry to push; ignored when st__push_5a=0.
- st__err_clr  input  1  clears both sticky error flags.
- st__tos_1a  output  WIDTH  registered top entry; 0 when empty.
- st__nos_1a  output  WIDTH  registered second entry; 0 when occupancy < 2.
- st__count  output  AW+1  registered occupancy, 0..DEPTH.
- st__empty  output  1  registered; high when st__count==0.
- st__full  output  1  registered; high when st__count==DEPTH.
- st__uflow  output  1  sticky underflow flag.
- st__oflow  output  1  sticky overflow flag.

Behaviour:
- Reset (rst_b low at a rising edge):
  - count=0, tos=0, nos=0, empty=1, full=0, uflow=0, oflow=0.
  - Storage array is not reset.
  - Reset overrides any request presented in the same cycle.
- Per cycle, with c = current count and p = st__to_pop_5a zero-extended:
  - Pop: if p <= c, then c1 = c - p. If p > c, then c1 = 0 and uflow is set. No wrap: the counter never goes negative.
  - Push: if st__push_5a=1 and c1 < DEPTH, then mem[c1] <= st__to_push_5a and count <= c1+1.
  - If st__push_5a=1 and c1 == DEPTH, the push is dropped, oflow is set and count <= c1. This is only reachable with p=0 while full.
  - If st__push_5a=0, count <= c1.
- Latency:
  - All effects are visible on the outputs one cycle after the request edge.
  - Back-to-back requests every cycle are supported; there is no stall or ready signal and the block always accepts.
- TOS/NOS update (same edge as count):
  - Derived from the post-operation state.
  - If the push occurred, tos <= pushed entry (bypass; not read back from mem) and nos <= mem[c1-1], or 0 if c1==0.
  - Otherwise tos <= mem[c1-1] and nos <= mem[c1-2], each 0 when its index would be negative.
  - Reads see pre-edge memory contents. The new write is never read through the array in the same cycle, so no read-during-write hazard.
- Pop-and-push with equal index (p=1, push=1): replaces TOS; count unchanged; tos shows the new value.
- Large pops (p >= DEPTH, up to 2047): treated per the pop rule. If p > c, uflow is set; if p == c, the pop is legal and empties the stack.
- Sticky flags:
  - uflow and oflow hold until st__err_clr=1 or reset.
  - If err_clr and a new error occur in the same cycle, the new error wins and the flag stays set.
- empty/full are recomputed from the next count. They are never both high.
- Reset asserted mid-stream discards the in-flight request. Storage content after reset is don't-care and is never exposed, because the outputs gate it by count.

Test Plan:
- Reset with push=1, pop=0, data=0x1_2345_6789 -> next cycle count=0, empty=1, tos=0, nos=0, flags=0.
- Push 0x1, 0x2, 0x3 on three consecutive cycles -> count=3, tos=0x3, nos=0x2; then pop=2 with push=0 -> count=1, tos=0x1, nos=0.
- With stack [0x1,0x2,0x3], pop=2 and push=1 with data 0x7 -> count=2, tos=0x7, nos=0x1; pop=1, push=1, data 0x9 -> count=2, tos=0x9, nos=0x1.
- count=2, pop=5, push=1, data 0xA -> uflow=1, count=1, tos=0xA, nos=0; uflow holds until err_clr pulse, then clears.
- Fill with DEPTH pushes -> full=1, count=DEPTH; another push 0x55 with pop=0 -> oflow=1, count=DEPTH, tos unchanged; same cycle as err_clr=1 -> oflow stays 1.
- pop=2047 on an empty stack -> uflow=1, count=0, empty=1; pop=DEPTH on a full stack -> count=0, uflow=0.

Source files
------------

// File: rtl/cpu_stack_file_if.sv
// Writeback-to-stack request bus and the registered stack status returned to the pipeline front.
// The master drives the pop/push request; the slave (the stack file) returns TOS/NOS, occupancy and flags.
interface cpu_stack_file_if #(
    parameter int WIDTH = 35,
    parameter int AW    = 6
);
    logic             st__push_5a;
    logic [10:0]      st__to_pop_5a;
    logic [WIDTH-1:0] st__to_push_5a;
    logic             st__err_clr;
    logic [WIDTH-1:0] st__tos_1a;
    logic [WIDTH-1:0] st__nos_1a;
    logic [AW:0]      st__count;
    logic             st__empty;
    logic             st__full;
    logic             st__uflow;
    logic             st__oflow;

    modport master (
        output st__push_5a,
        output st__to_pop_5a,
        output st__to_push_5a,
        output st__err_clr,
        input  st__tos_1a,
        input  st__nos_1a,
        input  st__count,
        input  st__empty,
        input  st__full,
        input  st__uflow,
        input  st__oflow
    );

    modport slave (
        input  st__push_5a,
        input  st__to_pop_5a,
        input  st__to_push_5a,
        input  st__err_clr,
        output st__tos_1a,
        output st__nos_1a,
        output st__count,
        output st__empty,
        output st__full,
        output st__uflow,
        output st__oflow
    );
endinterface

// File: rtl/cpu_stack_file.sv
// Operand stack for the stack CPU: each cycle applies "pop N, then optionally push one",
// and presents registered TOS/NOS, occupancy and sticky under/overflow status.
module cpu_stack_file #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int WIDTH = 35
) (
    input  logic                 clk,
    input  logic                 rst_b,
    cpu_stack_file_if.slave      st
);

    // Pop count is 11 bits; compare it against the occupancy in a width that holds both.
    localparam int          CMPW    = ((AW + 1) > 11) ? (AW + 1) : 11;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];

    logic [AW:0]      count_r;
    logic [WIDTH-1:0] tos_r;
    logic [WIDTH-1:0] nos_r;
    logic             empty_r;
    logic             full_r;
    logic             uflow_r;
    logic             oflow_r;

    logic [CMPW-1:0]  pop_ext_s;
    logic [CMPW-1:0]  cnt_ext_s;
    logic             uflow_ev_s;
    logic             oflow_ev_s;
    logic             push_ok_s;
    logic [AW:0]      c1_s;
    logic [AW-1:0]    idx1_s;
    logic [AW-1:0]    idx2_s;
    logic [WIDTH-1:0] rd1_s;
    logic [WIDTH-1:0] rd2_s;
    logic [AW:0]      count_nx_s;
    logic [WIDTH-1:0] tos_nx_s;
    logic [WIDTH-1:0] nos_nx_s;
    logic             uflow_nx_s;
    logic             oflow_nx_s;

    // Next-state computation: saturating pop, conditional push, post-operation TOS/NOS selection.
    always_comb begin
        pop_ext_s  = CMPW'(st.st__to_pop_5a);
        cnt_ext_s  = CMPW'(count_r);
        uflow_ev_s = (pop_ext_s > cnt_ext_s);

        if (uflow_ev_s) begin
            c1_s = '0;
        end else begin
            c1_s = count_r - pop_ext_s[AW:0];
        end

        push_ok_s  = st.st__push_5a && (c1_s != DEPTH_C);
        oflow_ev_s = st.st__push_5a && (c1_s == DEPTH_C);

        // Low-bit wrap is harmless: the read is only used when the index is non-negative.
        idx1_s = c1_s[AW-1:0] - AW'(2'd1);
        idx2_s = c1_s[AW-1:0] - AW'(2'd2);

        if (c1_s != '0) begin
            rd1_s = mem_r[idx1_s];
        end else begin
            rd1_s = {WIDTH{1'b0}};
        end

        if (c1_s > (AW + 1)'(2'd1)) begin
            rd2_s = mem_r[idx2_s];
        end else begin
            rd2_s = {WIDTH{1'b0}};
        end

        if (push_ok_s) begin
            count_nx_s = c1_s + (AW + 1)'(1'b1);
            tos_nx_s   = st.st__to_push_5a;
            nos_nx_s   = rd1_s;
        end else begin
            count_nx_s = c1_s;
            tos_nx_s   = rd1_s;
            nos_nx_s   = rd2_s;
        end

        // A fresh error beats a clear arriving in the same cycle.
        if (uflow_ev_s) begin
            uflow_nx_s = 1'b1;
        end else if (st.st__err_clr) begin
            uflow_nx_s = 1'b0;
        end else begin
            uflow_nx_s = uflow_r;
        end

        if (oflow_ev_s) begin
            oflow_nx_s = 1'b1;
        end else if (st.st__err_clr) begin
            oflow_nx_s = 1'b0;
        end else begin
            oflow_nx_s = oflow_r;
        end
    end

    // Status and output registers; reset wins over any request in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            count_r <= '0;
            tos_r   <= {WIDTH{1'b0}};
            nos_r   <= {WIDTH{1'b0}};
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            uflow_r <= 1'b0;
            oflow_r <= 1'b0;
        end else begin
            count_r <= count_nx_s;
            tos_r   <= tos_nx_s;
            nos_r   <= nos_nx_s;
            empty_r <= (count_nx_s == '0);
            full_r  <= (count_nx_s == DEPTH_C);
            uflow_r <= uflow_nx_s;
            oflow_r <= oflow_nx_s;
        end
    end

    // Storage array; not reset since outputs are always gated by the occupancy count.
    always_ff @(posedge clk) begin
        if (rst_b && push_ok_s) begin
            mem_r[c1_s[AW-1:0]] <= st.st__to_push_5a;
        end
    end

    assign st.st__tos_1a = tos_r;
    assign st.st__nos_1a = nos_r;
    assign st.st__count  = count_r;
    assign st.st__empty  = empty_r;
    assign st.st__full   = full_r;
    assign st.st__uflow  = uflow_r;
    assign st.st__oflow  = oflow_r;

endmodule

// File: tb/tb_cpu_stack_file.sv
// Table-driven bench for cpu_stack_file: each vector's expected outputs go into a scoreboard
// queue when driven and are popped and compared one cycle later.
module tb_cpu_stack_file;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int W     = 35;

    typedef struct packed {
        logic [AW:0]  count;
        logic [W-1:0] tos;
        logic [W-1:0] nos;
        logic         empty;
        logic         full;
        logic         uflow;
        logic         oflow;
    } exp_t;

    typedef struct {
        logic         rst_b;
        logic         push;
        logic [10:0]  pop;
        logic [W-1:0] data;
        logic         clr;
        exp_t         exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_b;

    always #5 clk = ~clk;

    cpu_stack_file_if #(.WIDTH(W), .AW(AW)) st_if();

    cpu_stack_file #(.DEPTH(DEPTH), .AW(AW), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .st    (st_if)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t ex(input int cnt, input logic [W-1:0] tos, input logic [W-1:0] nos,
                                input logic uf, input logic of);
        exp_t e;
        e.count = (AW + 1)'(cnt);
        e.tos   = tos;
        e.nos   = nos;
        e.empty = (cnt == 0);
        e.full  = (cnt == DEPTH);
        e.uflow = uf;
        e.oflow = of;
        return e;
    endfunction

    function automatic vec_t mk(input logic r, input logic push, input int pop,
                                input logic [W-1:0] data, input logic clr, input exp_t e);
        vec_t v;
        v.rst_b = r;
        v.push  = push;
        v.pop   = 11'(pop);
        v.data  = data;
        v.clr   = clr;
        v.exp   = e;
        return v;
    endfunction

    task automatic compare(input string tag);
        exp_t e;
        exp_t a;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, no expected record", tag);
        end else begin
            e = exp_q.pop_front();
            a.count = st_if.st__count;
            a.tos   = st_if.st__tos_1a;
            a.nos   = st_if.st__nos_1a;
            a.empty = st_if.st__empty;
            a.full  = st_if.st__full;
            a.uflow = st_if.st__uflow;
            a.oflow = st_if.st__oflow;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got cnt=%0d tos=%h nos=%h e/f/u/o=%b%b%b%b, want cnt=%0d tos=%h nos=%h e/f/u/o=%b%b%b%b",
                         tag, a.count, a.tos, a.nos, a.empty, a.full, a.uflow, a.oflow,
                         e.count, e.tos, e.nos, e.empty, e.full, e.uflow, e.oflow);
            end
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        rst_b                = v.rst_b;
        st_if.st__push_5a    = v.push;
        st_if.st__to_pop_5a  = v.pop;
        st_if.st__to_push_5a = v.data;
        st_if.st__err_clr    = v.clr;
        exp_q.push_back(v.exp);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    vec_t tbl_a[$];
    vec_t tbl_b[$];

    initial begin
        rst_b                = 1'b0;
        st_if.st__push_5a    = 1'b0;
        st_if.st__to_pop_5a  = 11'd0;
        st_if.st__to_push_5a = {W{1'b0}};
        st_if.st__err_clr    = 1'b0;

        // rst, push, pop, data, clr, expected(count, tos, nos, uflow, oflow)
        tbl_a.push_back(mk(1'b0, 1'b1, 0,    35'h1_2345_6789, 1'b0, ex(0, 35'h0, 35'h0, 1'b0, 1'b0)));
        tbl_a.push_back(mk(1'b1, 1'b1, 0,    35'h1,           1'b0, ex(1, 35'h1, 35'h0, 1'b0, 1'b0)));
        tbl_a.push_back(mk(1'b1, 1'b1, 0,    35'h2,           1'b0, ex(2, 35'h2, 35'h1, 1'b0, 1'b0)));
        tbl_a.push_back(mk(1'b1, 1'b1, 0,    35'h3,           1'b0, ex(3, 35'h3, 35'h2, 1'b0, 1'b0)));
        tbl_a.push_back(mk(1'b1, 1'b0, 2,    35'h0,           1'b0, ex(1, 35'h1, 35'h0, 1'b0, 1'b0)));
        tbl_a.push_back(mk(1'b1, 1'b1, 0,    35'h2,           1'b0, ex(2, 35'h2, 35'h1, 1'b0, 1'b0)));
        tbl_a.push_back(mk(1'b1, 1'b1, 0,    35'h3,           1'b0, ex(3, 35'h3, 35'h2, 1'b0, 1'b0)));
        tbl_a.push_back(mk(1'b1, 1'b1, 2,    35'h7,           1'b0, ex(2, 35'h7, 35'h1, 1'b0, 1'b0)));
        tbl_a.push_back(mk(1'b1, 1'b1, 1,    35'h9,           1'b0, ex(2, 35'h9, 35'h1, 1'b0, 1'b0)));
        tbl_a.push_back(mk(1'b1, 1'b1, 5,    35'hA,           1'b0, ex(1, 35'hA, 35'h0, 1'b1, 1'b0)));
        tbl_a.push_back(mk(1'b1, 1'b0, 0,    35'h0,           1'b0, ex(1, 35'hA, 35'h0, 1'b1, 1'b0)));
        tbl_a.push_back(mk(1'b1, 1'b0, 0,    35'h0,           1'b1, ex(1, 35'hA, 35'h0, 1'b0, 1'b0)));
        tbl_a.push_back(mk(1'b1, 1'b0, 1,    35'h0,           1'b0, ex(0, 35'h0, 35'h0, 1'b0, 1'b0)));
        tbl_a.push_back(mk(1'b1, 1'b0, 2047, 35'h0,           1'b0, ex(0, 35'h0, 35'h0, 1'b1, 1'b0)));
        tbl_a.push_back(mk(1'b1, 1'b0, 0,    35'h0,           1'b1, ex(0, 35'h0, 35'h0, 1'b0, 1'b0)));

        // After filling with 0x100..0x13F: overflow, clear-vs-error, full pop, mid-stream reset.
        tbl_b.push_back(mk(1'b1, 1'b1, 0,     35'h55, 1'b0, ex(DEPTH, 35'h13F, 35'h13E, 1'b0, 1'b1)));
        tbl_b.push_back(mk(1'b1, 1'b1, 0,     35'h55, 1'b1, ex(DEPTH, 35'h13F, 35'h13E, 1'b0, 1'b1)));
        tbl_b.push_back(mk(1'b1, 1'b0, 0,     35'h0,  1'b1, ex(DEPTH, 35'h13F, 35'h13E, 1'b0, 1'b0)));
        tbl_b.push_back(mk(1'b1, 1'b0, DEPTH, 35'h0,  1'b0, ex(0, 35'h0, 35'h0, 1'b0, 1'b0)));
        tbl_b.push_back(mk(1'b1, 1'b1, 0,     35'h5,  1'b0, ex(1, 35'h5, 35'h0, 1'b0, 1'b0)));
        tbl_b.push_back(mk(1'b0, 1'b1, 0,     35'h6,  1'b0, ex(0, 35'h0, 35'h0, 1'b0, 1'b0)));
        tbl_b.push_back(mk(1'b1, 1'b1, 3,     35'h7,  1'b0, ex(1, 35'h7, 35'h0, 1'b1, 1'b0)));

        for (int i = 0; i < tbl_a.size(); i++) begin
            apply(tbl_a[i], $sformatf("tbl_a[%0d]", i));
        end

        // Fill to DEPTH with back-to-back pushes.
        for (int i = 0; i < DEPTH; i++) begin
            apply(mk(1'b1, 1'b1, 0, W'(32'h100 + i), 1'b0,
                     ex(i + 1, W'(32'h100 + i), (i > 0) ? W'(32'h100 + i - 1) : {W{1'b0}}, 1'b0, 1'b0)),
                  $sformatf("fill[%0d]", i));
        end

        for (int i = 0; i < tbl_b.size(); i++) begin
            apply(tbl_b[i], $sformatf("tbl_b[%0d]", i));
        end

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d records left, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
